// File: rtl/fetch_pc_select_pkg.sv
// Shared y86 definitions: instruction codes and fetch FSM state encodings.
package fetch_pc_select_pkg;

   localparam logic [3:0] ICODE_HALT = 4'h0;
   localparam logic [3:0] ICODE_NOP  = 4'h1;
   localparam logic [3:0] ICODE_JXX  = 4'h7;
   localparam logic [3:0] ICODE_CALL = 4'h8;
   localparam logic [3:0] ICODE_RET  = 4'h9;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_RET_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_select_pc_predict.sv
// Next-PC prediction: taken for calls and jumps, fall-through otherwise.
module pc_predict
   import fetch_pc_select_pkg::*;
(
   input  logic [3:0]  i_icode,
   input  logic [63:0] i_valc,
   input  logic [63:0] i_valp,
   output logic [63:0] o_pred
);

   always_comb begin
      o_pred = i_valp;
      if ((i_icode == ICODE_CALL) || (i_icode == ICODE_JXX))
         o_pred = i_valc;
   end

endmodule

// File: rtl/fetch_pc_select.sv
// Fetch PC selection: redirect mux, predicted-PC register and ret/halt FSM.
module fetch_pc_select
   import fetch_pc_select_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  f_icode,
   input  logic [63:0] f_valC,
   input  logic [63:0] f_valP,
   input  logic        f_valid,
   input  logic        F_stall,
   input  logic [3:0]  M_icode,
   input  logic        M_cnd,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   output logic [63:0] f_pc,
   output logic [63:0] F_predPC,
   output logic        f_bubble,
   output logic [1:0]  f_state
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;
   fetch_state_t w_fetch_state;
   logic [63:0]  r_pred_pc;
   logic [63:0]  w_pred;
   logic         w_mispredict;
   logic         w_ret_wb;
   logic         w_load;

   assign w_mispredict = (M_icode == ICODE_JXX) && !M_cnd;
   assign w_ret_wb     = (W_icode == ICODE_RET);

   always_comb begin
      f_pc = r_pred_pc;
      if (w_mispredict)
         f_pc = M_valA;
      else if (w_ret_wb)
         f_pc = W_valM;
   end

   pc_predict u_pc_predict (
      .i_icode (f_icode),
      .i_valc  (f_valC),
      .i_valp  (f_valP),
      .o_pred  (w_pred)
   );

   // State a live fetch at f_pc leads to; a bad fetch parks the front end in HALT.
   always_comb begin
      w_fetch_state = ST_RUN;
      if ((f_icode == ICODE_RET) && f_valid)
         w_fetch_state = ST_RET_WAIT;
      else if ((f_icode == ICODE_HALT) || !f_valid)
         w_fetch_state = ST_HALT;
   end

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      f_bubble     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (!F_stall || w_mispredict) begin
               w_load       = 1'b1;
               w_next_state = w_fetch_state;
            end
         end
         ST_RET_WAIT: begin
            if (w_mispredict) begin
               w_load       = 1'b1;
               w_next_state = ST_RUN;
            end else if (w_ret_wb) begin
               // The return target is fetched now, so its own ret/halt counts.
               w_load       = 1'b1;
               w_next_state = w_fetch_state;
            end else begin
               f_bubble     = 1'b1;
            end
         end
         ST_HALT: begin
            if (w_mispredict) begin
               w_load       = 1'b1;
               w_next_state = ST_RUN;
            end else begin
               f_bubble     = 1'b1;
            end
         end
         default: w_next_state = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_pred_pc <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_load)
            r_pred_pc <= w_pred;
      end
   end

   assign F_predPC = r_pred_pc;
   assign f_state  = r_state;

endmodule
